// File: rtl/trackball_pkg.sv
// rtl/trackball_pkg.sv - shared types, Gray encoder and saturation limits for trackball_quad
package trackball_pkg;

    typedef logic [1:0] phase_t;

    localparam int ACC_W_DEFAULT  = 12;
    localparam int SAT_HI_DEFAULT = (1 << (ACC_W_DEFAULT - 1)) - 1;
    localparam int SAT_LO_DEFAULT = -SAT_HI_DEFAULT;

    // Quadrature phase 0..3 -> {A,B} = 00, 01, 11, 10
    function automatic logic [1:0] gray_enc(input phase_t p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    // Symmetric clamp limit for an accumulator of the given width
    function automatic int sat_hi(input int acc_w);
        return (1 << (acc_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// rtl/trackball_axis.sv - one axis: accumulator, saturation, phase counter, output encoding
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int DELTA_W = 9,
    parameter int ACC_W   = 12
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               pkt_evt_i,
    input  logic               tick_i,
    input  logic [DELTA_W-1:0] delta_i,
    input  logic               flip_i,
    input  logic               mode_i,
    output logic               quad_a_o,
    output logic               quad_b_o,
    output logic               busy_o,
    output logic               sat_o
);

    localparam logic signed [ACC_W:0] LIM_HI = (ACC_W+1)'(sat_hi(ACC_W));
    localparam logic signed [ACC_W:0] LIM_LO = -LIM_HI;
    localparam logic signed [ACC_W:0] ONE    = (ACC_W+1)'(1);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] dext, dcond;
    logic signed [ACC_W:0]   sum;
    phase_t                  phase_q, phase_d;
    logic                    dir_q, dir_d;
    logic                    step_pos, step_neg, clamp;
    logic [1:0]              ab_d;
    logic                    quad_a_q, quad_b_q, busy_q, sat_q;

    // The extra accumulator bit makes negating the most negative delta exact
    assign dext     = {{(ACC_W-DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
    assign dcond    = flip_i ? -dext : dext;
    assign step_pos = tick_i & ~acc_q[ACC_W-1] & (acc_q != '0);
    assign step_neg = tick_i & acc_q[ACC_W-1];

    // Next accumulator: drain one step toward zero, add packet, clamp symmetrically
    always_comb begin
        sum   = {acc_q[ACC_W-1], acc_q};
        clamp = 1'b0;
        if (step_pos) sum = sum - ONE;
        if (step_neg) sum = sum + ONE;
        if (pkt_evt_i) sum = sum + {dcond[ACC_W-1], dcond};
        if (sum > LIM_HI) begin
            acc_d = LIM_HI[ACC_W-1:0];
            clamp = 1'b1;
        end else if (sum < LIM_LO) begin
            acc_d = LIM_LO[ACC_W-1:0];
            clamp = 1'b1;
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // Phase follows the step; output mapping uses the post-step phase so it lands on the same edge
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        if (step_pos) begin
            phase_d = phase_q + 2'd1;
            dir_d   = 1'b1;
        end else if (step_neg) begin
            phase_d = phase_q - 2'd1;
            dir_d   = 1'b0;
        end
        ab_d = mode_i ? {dir_d, phase_d[0]} : gray_enc(phase_d);
    end

    // Axis state and registered outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_q    <= '0;
            phase_q  <= '0;
            dir_q    <= 1'b0;
            quad_a_q <= 1'b0;
            quad_b_q <= 1'b0;
            busy_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            quad_a_q <= ab_d[1];
            quad_b_q <= ab_d[0];
            busy_q   <= (acc_d != '0);
            sat_q    <= clamp;
        end
    end

    assign quad_a_o = quad_a_q;
    assign quad_b_o = quad_b_q;
    assign busy_o   = busy_q;
    assign sat_o    = sat_q;

endmodule

// File: rtl/trackball_quad.sv
// rtl/trackball_quad.sv - multi-axis relative-motion to quadrature / dir-clock emulator
module trackball_quad
    import trackball_pkg::*;
#(
    parameter int AXES    = 2,
    parameter int DELTA_W = 9,
    parameter int ACC_W   = 12,
    parameter int DIV_W   = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    pkt_toggle,
    input  logic [AXES*DELTA_W-1:0] delta,
    input  logic [AXES-1:0]         flip,
    input  logic [DIV_W-1:0]        rate,
    input  logic                    mode,
    output logic [AXES-1:0]         quad_a,
    output logic [AXES-1:0]         quad_b,
    output logic [AXES-1:0]         busy,
    output logic [AXES-1:0]         sat
);

    logic             pkt_prev_q;
    logic             pkt_evt;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    // Track the toggle level; loading it during reset keeps release event-free
    always_ff @(posedge clk_sys) begin
        if (!reset_n) pkt_prev_q <= pkt_toggle;
        else          pkt_prev_q <= pkt_toggle;
    end

    assign pkt_evt = (pkt_toggle != pkt_prev_q);
    assign tick    = (div_q == '0);

    // Shared step-rate prescaler; rate is only sampled on reload
    always_ff @(posedge clk_sys) begin
        if (!reset_n || tick) div_q <= rate;
        else                  div_q <= div_q - DIV_W'(1);
    end

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        trackball_axis #(
            .DELTA_W (DELTA_W),
            .ACC_W   (ACC_W)
        ) u_axis (
            .clk_sys   (clk_sys),
            .reset_n   (reset_n),
            .pkt_evt_i (pkt_evt),
            .tick_i    (tick),
            .delta_i   (delta[i*DELTA_W +: DELTA_W]),
            .flip_i    (flip[i]),
            .mode_i    (mode),
            .quad_a_o  (quad_a[i]),
            .quad_b_o  (quad_b[i]),
            .busy_o    (busy[i]),
            .sat_o     (sat[i])
        );
    end

endmodule

// File: tb/tb_trackball_quad.sv
// tb/tb_trackball_quad.sv - scoreboard bench for trackball_quad
module tb_trackball_quad;

    localparam int AXES    = 2;
    localparam int DELTA_W = 9;
    localparam int ACC_W   = 12;
    localparam int DIV_W   = 8;

    logic                    clk_sys = 1'b0;
    logic                    reset_n;
    logic                    pkt_toggle;
    logic [AXES*DELTA_W-1:0] delta;
    logic [AXES-1:0]         flip;
    logic [DIV_W-1:0]        rate;
    logic                    mode;
    logic [AXES-1:0]         quad_a, quad_b, busy, sat;

    trackball_quad #(
        .AXES(AXES), .DELTA_W(DELTA_W), .ACC_W(ACC_W), .DIV_W(DIV_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .pkt_toggle (pkt_toggle),
        .delta      (delta),
        .flip       (flip),
        .rate       (rate),
        .mode       (mode),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk_sys = ~clk_sys;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard of expected axis0 {A,B} codes, one per step
    logic [1:0] exp_q[$];
    logic [1:0] m_phase;
    logic       m_dir;
    bit         mon_en = 1'b0;
    logic [1:0] prev0, prev1, cur0, cur1, e;
    int         cyc = 0;
    int         last_cyc = 0;
    bit         have_last = 1'b0;
    bit         sp_chk = 1'b0;
    int         sp_val = 0;
    int         sat_cnt = 0;

    function automatic logic [1:0] gray_tb(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic push_steps(input int n, input bit m1);
        int cnt;
        cnt = (n < 0) ? -n : n;
        for (int k = 0; k < cnt; k++) begin
            if (n > 0) m_phase = m_phase + 2'd1;
            else       m_phase = m_phase - 2'd1;
            m_dir = (n > 0);
            exp_q.push_back(m1 ? {m_dir, m_phase[0]} : gray_tb(m_phase));
        end
    endtask

    // Output monitor: every change on axis0 must match the next scoreboard entry
    always @(posedge clk_sys) begin
        cyc++;
        #1;
        if (mon_en) begin
            cur0 = {quad_a[0], quad_b[0]};
            cur1 = {quad_a[1], quad_b[1]};
            if (cur0 !== prev0) begin
                if (exp_q.size() == 0) begin
                    check("unexp_step0", 32'(cur0), 32'(prev0));
                end else begin
                    e = exp_q.pop_front();
                    check("ab0", 32'(cur0), 32'(e));
                    if (sp_chk && have_last) check("spacing", cyc - last_cyc, sp_val);
                    have_last = 1'b1;
                    last_cyc  = cyc;
                end
                prev0 = cur0;
            end
            if (cur1 !== prev1) begin
                check("ax1_static", 32'(cur1), 32'(prev1));
                prev1 = cur1;
            end
            sat_cnt += int'(sat[0]);
        end
    end

    task automatic resync();
        exp_q.delete();
        m_phase   = 2'd0;
        m_dir     = 1'b0;
        prev0     = {quad_a[0], quad_b[0]};
        prev1     = {quad_a[1], quad_b[1]};
        have_last = 1'b0;
        mon_en    = 1'b1;
    endtask

    task automatic do_reset(input int n);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        repeat (n) @(posedge clk_sys);
        #3;
        reset_n = 1'b1;
        resync();
    endtask

    task automatic send_pkt(input int d0, input int d1);
        delta      = {DELTA_W'(d1), DELTA_W'(d0)};
        pkt_toggle = ~pkt_toggle;
        @(posedge clk_sys);
        #3;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #3;
    endtask

    task automatic drain(input string tag, input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(posedge clk_sys);
            #3;
            k++;
        end
        check({"drain_", tag}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int s0;

    initial begin
        reset_n    = 1'b0;
        pkt_toggle = 1'b1;
        delta      = {DELTA_W'(0), DELTA_W'(5)};
        flip       = '0;
        rate       = 8'd3;
        mode       = 1'b0;
        @(posedge clk_sys);
        #3;

        // Reset: toggle held at 1 through release, non-zero delta present
        do_reset(4);
        idle(12);
        check("rst_quad_a", 32'(quad_a), 0);
        check("rst_quad_b", 32'(quad_b), 0);
        check("rst_busy",   32'(busy),   0);
        check("rst_sat",    32'(sat),    0);

        // Positive run, rate 3, mode 0
        rate = 8'd3;
        do_reset(2);
        sp_chk = 1'b1;
        sp_val = 4;
        s0 = sat_cnt;
        push_steps(5, 1'b0);
        send_pkt(5, 0);
        check("pos_busy_on", 32'(busy[0]), 1);
        drain("pos", 100);
        check("pos_busy_fall", 32'(busy[0]), 0);
        check("pos_no_sat", sat_cnt - s0, 0);
        sp_chk = 1'b0;
        idle(8);
        check("pos_ax1", 32'({quad_a[1], quad_b[1], busy[1]}), 0);

        // Negative run
        rate = 8'd1;
        do_reset(2);
        push_steps(-3, 1'b0);
        send_pkt(-3, 0);
        drain("neg", 50);
        check("neg_busy", 32'(busy[0]), 0);
        idle(4);

        // Same packet with flip
        flip = 2'b01;
        do_reset(2);
        push_steps(3, 1'b0);
        send_pkt(-3, 0);
        drain("flip", 50);
        check("flip_busy", 32'(busy[0]), 0);
        idle(4);
        flip = 2'b00;

        // Direction/clock mode, negative delta
        mode = 1'b1;
        do_reset(2);
        push_steps(-3, 1'b1);
        send_pkt(-3, 0);
        drain("mode1", 50);
        check("mode1_dir", 32'(quad_a[0]), 0);
        idle(4);
        mode = 1'b0;

        // Saturation: nine +255 packets before the first tick
        rate = 8'd255;
        do_reset(2);
        s0 = sat_cnt;
        push_steps(2047, 1'b0);
        for (int k = 0; k < 8; k++) send_pkt(255, 0);
        check("sat_early", sat_cnt - s0, 0);
        send_pkt(255, 0);
        check("sat_pulse", 32'(sat[0]), 1);
        rate = 8'd0;
        drain("sat", 3000);
        check("sat_busy", 32'(busy[0]), 0);
        check("sat_once", sat_cnt - s0, 1);
        idle(4);

        // Tick and packet in the same cycle
        rate = 8'd0;
        do_reset(2);
        push_steps(2, 1'b0);
        send_pkt(1, 0);
        check("sim_nostep", exp_q.size(), 2);
        send_pkt(1, 0);
        check("sim_onestep", exp_q.size(), 1);
        check("sim_busy", 32'(busy[0]), 1);
        drain("sim", 10);
        check("sim_busy_end", 32'(busy[0]), 0);
        idle(4);

        // Reset mid-stream
        rate = 8'd3;
        do_reset(2);
        push_steps(100, 1'b0);
        send_pkt(100, 0);
        idle(20);
        check("mid_busy_before", 32'(busy[0]), 1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check("mid_quad", 32'({quad_a, quad_b}), 0);
        check("mid_busy", 32'(busy), 0);
        resync();
        idle(60);
        check("mid_idle_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
